// File: rtl/joystick_sampler.sv
// Joystick front end for an MCP3008 SPI driver: paces conversions, averages X/Y
// over 2^AVG_LOG2 samples, decodes a deadzoned direction and flags driver timeouts.
module joystick_sampler #(
    parameter int unsigned SAMPLE_PERIOD = 50000,
    parameter int unsigned TIMEOUT       = 2000,
    parameter int unsigned AVG_LOG2      = 2,
    parameter int unsigned CENTER        = 512,
    parameter int unsigned DEADZONE      = 100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    output logic       adc_start,
    input  logic [9:0] adc_x,
    input  logic [9:0] adc_y,
    input  logic       adc_valid,
    output logic [9:0] x_avg,
    output logic [9:0] y_avg,
    output logic [3:0] dir,
    output logic       sample_valid,
    output logic       timeout_err,
    input  logic       err_clr
);

    localparam int unsigned PW    = $clog2(SAMPLE_PERIOD);
    localparam int unsigned TW    = $clog2(TIMEOUT + 1);
    localparam int unsigned SW    = 10 + AVG_LOG2;
    localparam int unsigned CW    = AVG_LOG2 + 1;
    localparam int unsigned NSAMP = 1 << AVG_LOG2;
    localparam logic [10:0] HI    = 11'(CENTER + DEADZONE);
    localparam logic [10:0] LO    = 11'(CENTER - DEADZONE);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_OUT
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [PW-1:0]   r_period;
    logic [TW-1:0]   r_tcnt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_inc;
    logic [SW-1:0]   r_sum_x;
    logic [SW-1:0]   r_sum_y;
    logic [SW-1:0]   w_sum_x_next;
    logic [SW-1:0]   w_sum_y_next;
    logic [9:0]      w_x_new;
    logic [9:0]      w_y_new;
    logic [9:0]      r_x_avg;
    logic [9:0]      r_y_avg;
    logic [3:0]      r_dir;
    logic            r_err;
    logic            w_tick;
    logic            w_accept;
    logic            w_last;
    logic            w_timeout;

    assign w_tick       = (r_period == PW'(SAMPLE_PERIOD - 1));
    assign w_cnt_inc    = r_cnt + CW'(1);
    assign w_sum_x_next = r_sum_x + SW'(adc_x);
    assign w_sum_y_next = r_sum_y + SW'(adc_y);
    assign w_x_new      = 10'(w_sum_x_next >> AVG_LOG2);
    assign w_y_new      = 10'(w_sum_y_next >> AVG_LOG2);

    assign x_avg       = r_x_avg;
    assign y_avg       = r_y_avg;
    assign dir         = r_dir;
    assign timeout_err = r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_period <= '0;
        end else if (!enable || w_tick) begin
            r_period <= '0;
        end else begin
            r_period <= r_period + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        adc_start    = 1'b0;
        sample_valid = 1'b0;
        w_accept     = 1'b0;
        w_last       = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_tick && enable) begin
                    adc_start    = 1'b1;
                    w_state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (adc_valid) begin
                    w_accept = 1'b1;
                    if (w_cnt_inc == CW'(NSAMP)) begin
                        w_last       = 1'b1;
                        w_state_next = S_OUT;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end else if (r_tcnt == TW'(TIMEOUT - 1)) begin
                    w_timeout    = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            S_OUT: begin
                sample_valid = 1'b1;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // r_tcnt counts cycles since the adc_start cycle (that cycle being 0),
    // so timeout_err rises exactly TIMEOUT cycles after the start pulse.
    // Averages and direction are registered on the last accepted sample so
    // they are already stable while sample_valid is high in S_OUT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tcnt  <= '0;
            r_cnt   <= '0;
            r_sum_x <= '0;
            r_sum_y <= '0;
            r_x_avg <= 10'(CENTER);
            r_y_avg <= 10'(CENTER);
            r_dir   <= '0;
            r_err   <= 1'b0;
        end else begin
            if (adc_start) begin
                r_tcnt <= TW'(1);
            end else if (r_state == S_WAIT) begin
                r_tcnt <= r_tcnt + TW'(1);
            end

            if (w_timeout || w_last) begin
                r_cnt   <= '0;
                r_sum_x <= '0;
                r_sum_y <= '0;
            end else if (w_accept) begin
                r_cnt   <= w_cnt_inc;
                r_sum_x <= w_sum_x_next;
                r_sum_y <= w_sum_y_next;
            end

            if (w_last) begin
                r_x_avg <= w_x_new;
                r_y_avg <= w_y_new;
                r_dir   <= {({1'b0, w_y_new} > HI), ({1'b0, w_y_new} < LO),
                            ({1'b0, w_x_new} < LO), ({1'b0, w_x_new} > HI)};
            end

            if (w_timeout) begin
                r_err <= 1'b1;
            end else if (err_clr) begin
                r_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_joystick_sampler.sv
// Directed bench for joystick_sampler: pacing, averaging, deadzone decode,
// timeout handling, dropped ticks, enable gating and mid-transaction reset.
module tb_joystick_sampler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en, av, clr;
    logic [9:0] ax, ay;
    logic       st, sv, terr;
    logic [9:0] xa, ya;
    logic [3:0] dr;

    logic       b_en, b_av;
    logic [9:0] b_ax, b_ay;
    logic       b_st, b_sv, b_terr;
    logic [9:0] b_xa, b_ya;
    logic [3:0] b_dr;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    joystick_sampler #(.SAMPLE_PERIOD(100), .TIMEOUT(50), .AVG_LOG2(2),
                       .CENTER(512), .DEADZONE(100)) dut (
        .clk(clk), .rst_n(rst_n), .enable(en), .adc_start(st),
        .adc_x(ax), .adc_y(ay), .adc_valid(av), .x_avg(xa), .y_avg(ya),
        .dir(dr), .sample_valid(sv), .timeout_err(terr), .err_clr(clr)
    );

    joystick_sampler #(.SAMPLE_PERIOD(100), .TIMEOUT(200), .AVG_LOG2(2),
                       .CENTER(512), .DEADZONE(100)) dut2 (
        .clk(clk), .rst_n(rst_n), .enable(b_en), .adc_start(b_st),
        .adc_x(b_ax), .adc_y(b_ay), .adc_valid(b_av), .x_avg(b_xa), .y_avg(b_ya),
        .dir(b_dr), .sample_valid(b_sv), .timeout_err(b_terr), .err_clr(1'b0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_start(output int at);
        int n;
        n = 0;
        while (st !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("start_seen", st, 1);
        at = cyc;
    endtask

    // Answer the next adc_start after lat cycles; returns one cycle after the strobe.
    task automatic sample(input int lat, input logic [9:0] x, input logic [9:0] y, output int at);
        wait_start(at);
        @(negedge clk);
        chk("start_width", st, 0);
        repeat (lat - 1) @(negedge clk);
        av = 1'b1; ax = x; ay = y;
        @(negedge clk);
        av = 1'b0;
    endtask

    task automatic avg4(input string tag, input logic [9:0] x, input logic [9:0] y,
                        input logic [9:0] ex, input logic [9:0] ey, input logic [3:0] ed);
        int t;
        for (int k = 0; k < 4; k++) begin
            sample(30, x, y, t);
            chk({tag, "_sv"}, sv, (k == 3) ? 1 : 0);
        end
        chk({tag, "_xavg"}, xa, ex);
        chk({tag, "_yavg"}, ya, ey);
        chk({tag, "_dir"}, dr, ed);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, prev, n, nst, first, second, nsv;
        rst_n = 1'b0; en = 1'b0; av = 1'b0; clr = 1'b0; ax = '0; ay = '0;
        b_en = 1'b0; b_av = 1'b0; b_ax = '0; b_ay = '0;
        #12;
        chk("rst_start", st, 0);
        chk("rst_sv", sv, 0);
        chk("rst_err", terr, 0);
        chk("rst_dir", dr, 0);
        chk("rst_xavg", xa, 512);
        chk("rst_yavg", ya, 512);
        @(negedge clk);
        rst_n = 1'b1; en = 1'b1;

        // Pacing and first average: (900+902+904+906)/4 = 903
        prev = 0;
        for (int k = 0; k < 4; k++) begin
            sample(30, 10'(900 + 2 * k), 10'd512, t);
            if (k > 0) chk("start_spacing", t - prev, 100);
            prev = t;
            chk("avg1_sv", sv, (k == 3) ? 1 : 0);
        end
        chk("avg1_xavg", xa, 903);
        chk("avg1_yavg", ya, 512);
        chk("avg1_dir", dr, 4'b0001);
        @(negedge clk);
        chk("sv_one_cycle", sv, 0);

        // Deadzone boundaries
        avg4("edge_in", 10'd612, 10'd412, 10'd612, 10'd412, 4'b0000);
        avg4("edge_out", 10'd411, 10'd613, 10'd411, 10'd613, 4'b1010);
        avg4("extreme", 10'd0, 10'd1023, 10'd0, 10'd1023, 4'b1010);

        // Timeout discards a partial average
        sample(30, 10'd100, 10'd100, t);
        wait_start(t);
        repeat (49) @(negedge clk);
        chk("to_before", terr, 0);
        @(negedge clk);
        chk("to_fire", terr, 1);
        avg4("after_to", 10'd700, 10'd512, 10'd700, 10'd512, 4'b0001);
        chk("err_sticky", terr, 1);
        wait_start(t);
        repeat (49) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("set_wins", terr, 1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("err_clr", terr, 0);

        // Dropped tick, enable low mid-wait, stray strobe (TIMEOUT=200 instance)
        b_en = 1'b1;
        n = 0;
        while (b_st !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("b_start_seen", b_st, 1);
        nst = 0; first = 0; second = 0; nsv = 0;
        for (int i = 1; i < 600; i++) begin
            @(negedge clk);
            if (b_st === 1'b1) begin
                nst++;
                if (nst == 1) first = i;
                else if (nst == 2) second = i;
            end
            if (b_sv === 1'b1) nsv++;
            b_en = (i < 310);
            b_av = (i == 120 || i == 230 || i == 340 || i == 400);
            b_ax = (i == 400) ? 10'd0 : 10'd800;
            b_ay = (i == 400) ? 10'd1023 : 10'd300;
        end
        b_av = 1'b0;
        chk("b_nstarts", nst, 2);
        chk("b_first_start", first, 200);
        chk("b_second_start", second, 300);
        chk("b_no_sv", nsv, 0);
        chk("b_xavg_hold", b_xa, 512);
        chk("b_no_err", b_terr, 0);
        b_en = 1'b1;
        n = 0;
        while (b_st !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("b_restart_seen", b_st, 1);
        repeat (10) @(negedge clk);
        b_av = 1'b1; b_ax = 10'd800; b_ay = 10'd300;
        @(negedge clk);
        b_av = 1'b0;
        chk("b_sv", b_sv, 1);
        chk("b_xavg", b_xa, 800);
        chk("b_yavg", b_ya, 300);
        chk("b_dir", b_dr, 4'b0101);

        // Reset in S_WAIT with two samples accumulated
        sample(30, 10'd1000, 10'd1000, t);
        sample(30, 10'd1000, 10'd1000, t);
        wait_start(t);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_start", st, 0);
        chk("mid_rst_sv", sv, 0);
        chk("mid_rst_err", terr, 0);
        chk("mid_rst_dir", dr, 0);
        chk("mid_rst_xavg", xa, 512);
        chk("mid_rst_yavg", ya, 512);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        av = 1'b1; ax = 10'd0; ay = 10'd0;
        @(negedge clk);
        av = 1'b0;
        chk("stray_sv", sv, 0);
        chk("stray_xavg", xa, 512);
        avg4("post_rst", 10'd200, 10'd800, 10'd200, 10'd800, 4'b1010);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
